// File: rtl/pwm_peripheral.sv
// pwm_peripheral: 16-channel PWM / static-drive output block.
// A prescaler divides clk into counter ticks; an 8-bit counter runs 0..254
// (255 ticks per period) and is compared against the active duty value.
// Each output bit is either forced low, forced high, or follows the PWM wave,
// selected per bit by the enable and PWM-select inputs. All outputs are
// registered (one clk of latency).
// Build option: define PWM_SHADOW_EN to load the duty value only at the
// period wrap (glitch-free duty updates); otherwise duty changes apply at once.
module pwm_peripheral #(
  parameter int unsigned PRESCALE = 13
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] out,
  output logic        period_start
);

  localparam logic [7:0] PS_MAX  = 8'(PRESCALE - 1);
  localparam logic [7:0] CNT_MAX = 8'd254;

  logic [7:0]  r_prescaler;
  logic [7:0]  r_counter;
  logic [7:0]  w_duty_active;
  logic        w_tick;
  logic        w_wrap;
  logic        w_pwm_raw;
  logic [15:0] w_en_out;
  logic [15:0] w_en_pwm;
  logic [15:0] w_out_next;
  logic [15:0] r_out;
  logic        r_period_start;

  assign w_tick    = (r_prescaler == PS_MAX);
  assign w_wrap    = w_tick && (r_counter == CNT_MAX);
  assign w_en_out  = {en_reg_out_15_8, en_reg_out_7_0};
  assign w_en_pwm  = {en_reg_pwm_15_8, en_reg_pwm_7_0};
  assign w_pwm_raw = (r_counter < w_duty_active);

  // Prescaler: free-running 0..PRESCALE-1, tick on its last count
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_prescaler <= '0;
    end else if (w_tick) begin
      r_prescaler <= '0;
    end else begin
      r_prescaler <= r_prescaler + 8'd1;
    end
  end

  // PWM counter: advances once per tick, wraps 254 -> 0
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_counter <= '0;
    end else if (w_tick) begin
      r_counter <= w_wrap ? '0 : (r_counter + 8'd1);
    end
  end

`ifdef PWM_SHADOW_EN
  logic [7:0] r_duty_shadow;

  // Shadow duty: sampled only on the wrapping tick so a period never changes shape
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_duty_shadow <= '0;
    end else if (w_wrap) begin
      r_duty_shadow <= pwm_duty_cycle;
    end
  end

  assign w_duty_active = r_duty_shadow;
`else
  assign w_duty_active = pwm_duty_cycle;
`endif

  // Per-bit output select: disabled -> 0, enabled static -> 1, enabled PWM -> wave
  always_comb begin
    w_out_next = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      w_out_next[i] = w_en_out[i] & (w_en_pwm[i] ? w_pwm_raw : 1'b1);
    end
  end

  // Output registers: drive bits and the one-clk period-start pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out          <= '0;
      r_period_start <= 1'b0;
    end else begin
      r_out          <= w_out_next;
      r_period_start <= w_wrap;
    end
  end

  assign out          = r_out;
  assign period_start = r_period_start;

endmodule

// File: tb/tb_pwm_peripheral.sv
// Self-checking bench for pwm_peripheral: table of directed vectors
// (reset, configure, run N clk, compare) plus hand-written multi-cycle sequences.
// A second instance with PRESCALE=1 shares the inputs.
module tb_pwm_peripheral;

  logic        clk;
  logic        rst_n;
  logic [15:0] en_out;
  logic [15:0] en_pwm;
  logic [7:0]  duty;
  logic [15:0] out;
  logic        period_start;
  logic [15:0] out1;
  logic        period_start1;

  int unsigned n_tests;
  int unsigned n_fail;

  pwm_peripheral #(.PRESCALE(13)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .en_reg_out_7_0  (en_out[7:0]),
    .en_reg_out_15_8 (en_out[15:8]),
    .en_reg_pwm_7_0  (en_pwm[7:0]),
    .en_reg_pwm_15_8 (en_pwm[15:8]),
    .pwm_duty_cycle  (duty),
    .out             (out),
    .period_start    (period_start)
  );

  pwm_peripheral #(.PRESCALE(1)) dut1 (
    .clk             (clk),
    .rst_n           (rst_n),
    .en_reg_out_7_0  (en_out[7:0]),
    .en_reg_out_15_8 (en_out[15:8]),
    .en_reg_pwm_7_0  (en_pwm[7:0]),
    .en_reg_pwm_15_8 (en_pwm[15:8]),
    .pwm_duty_cycle  (duty),
    .out             (out1),
    .period_start    (period_start1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] en_out;
    logic [15:0] en_pwm;
    logic [7:0]  duty;
    int unsigned n;        // clk edges after reset release
    logic [15:0] exp_out;
    logic        exp_ps;
  } vec_t;

  vec_t vecs[14];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reset for two clk; on return the next edge is the first one with rst_n high
  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    int unsigned ones, zeros, pulses, last_pulse, bad_gap, ones1, pulses1, bad_gap1, last1, first_ps;
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    en_out  = '0;
    en_pwm  = '0;
    duty    = '0;

    // Output after edge n reflects counter floor((n-1)/13); wrap pulse after edge 3315
    vecs[0]  = '{"static_first",  16'hFFFF, 16'h0000, 8'h00, 1,    16'hFFFF, 1'b0};
    vecs[1]  = '{"static_later",  16'hFFFF, 16'h0000, 8'h00, 2000, 16'hFFFF, 1'b0};
    vecs[2]  = '{"d80_first",     16'h0001, 16'h0001, 8'h80, 1,    16'h0001, 1'b0};
    vecs[3]  = '{"d80_lasthigh",  16'h0001, 16'h0001, 8'h80, 1664, 16'h0001, 1'b0};
    vecs[4]  = '{"d80_firstlow",  16'h0001, 16'h0001, 8'h80, 1665, 16'h0000, 1'b0};
    vecs[5]  = '{"d80_wrap",      16'h0001, 16'h0001, 8'h80, 3315, 16'h0000, 1'b1};
    vecs[6]  = '{"d80_newperiod", 16'h0001, 16'h0001, 8'h80, 3316, 16'h0001, 1'b0};
    vecs[7]  = '{"d00_bit15",     16'h8000, 16'h8000, 8'h00, 1,    16'h0000, 1'b0};
    vecs[8]  = '{"dFF_bit15_end", 16'h8000, 16'h8000, 8'hFF, 3315, 16'h8000, 1'b1};
    vecs[9]  = '{"mix_high",      16'h00FF, 16'h000F, 8'h10, 200,  16'h00FF, 1'b0};
    vecs[10] = '{"mix_low",       16'h00FF, 16'h000F, 8'h10, 209,  16'h00F0, 1'b0};
    vecs[11] = '{"a5_high",       16'hA5A5, 16'hFF00, 8'h05, 65,   16'hA5A5, 1'b0};
    vecs[12] = '{"a5_low",        16'hA5A5, 16'hFF00, 8'h05, 70,   16'h00A5, 1'b0};
    vecs[13] = '{"disabled",      16'h0000, 16'hFFFF, 8'hFF, 40,   16'h0000, 1'b0};

    // Reset state
    en_out = 16'hFFFF;
    duty   = 8'hFF;
    do_reset();
    check("reset_out", 32'(out), 32'h0);
    check("reset_ps", 32'(period_start), 32'h0);

    // Table-driven vectors
    for (int v = 0; v < 14; v++) begin
      en_out = vecs[v].en_out;
      en_pwm = vecs[v].en_pwm;
      duty   = vecs[v].duty;
      do_reset();
      for (int unsigned k = 0; k < vecs[v].n; k++) step();
      check({vecs[v].name, "_out"}, 32'(out), 32'(vecs[v].exp_out));
      check({vecs[v].name, "_ps"}, 32'(period_start), 32'(vecs[v].exp_ps));
    end

    // Duty 0x80 over a full period: 1664 high, 1651 low; PRESCALE=1 gives 128 high
    en_out = 16'h0001;
    en_pwm = 16'h0001;
    duty   = 8'h80;
    do_reset();
    ones = 0; zeros = 0; ones1 = 0;
    for (int unsigned k = 1; k <= 3315; k++) begin
      step();
      if (out[0]) ones++; else zeros++;
      if (out[15:1] != 15'h0) zeros = zeros + 10000;
      if (k <= 255 && out1[0]) ones1++;
    end
    check("d80_high_clk", ones, 1664);
    check("d80_low_clk", zeros, 1651);
    check("ps1_d80_high_clk", ones1, 128);

    // Duty 0x00 then 0xFF on bit 15 over three periods; pulse spacing for both instances
    for (int pass = 0; pass < 2; pass++) begin
      en_out = 16'h8000;
      en_pwm = 16'h8000;
      duty   = (pass == 0) ? 8'h00 : 8'hFF;
      do_reset();
      ones = 0; zeros = 0; pulses = 0; last_pulse = 0; bad_gap = 0;
      pulses1 = 0; last1 = 0; bad_gap1 = 0;
      for (int unsigned k = 1; k <= 9945; k++) begin
        step();
        if (out[15]) ones++; else zeros++;
        if (period_start) begin
          if (k - last_pulse != 3315) bad_gap++;
          pulses++;
          last_pulse = k;
        end
        if (period_start1) begin
          if (k - last1 != 255) bad_gap1++;
          pulses1++;
          last1 = k;
        end
      end
      if (pass == 0) check("d00_high_clk", ones, 0);
      else           check("dFF_low_clk", zeros, 0);
      check("ps_count_3per", pulses, 3);
      check("ps_gap_errors", bad_gap, 0);
      check("ps1_count", pulses1, 39);
      check("ps1_gap_errors", bad_gap1, 0);
    end

    // One-clk reset at counter 0x90 aborts the period
    en_out = 16'hFFFF;
    en_pwm = 16'h0000;
    duty   = 8'h80;
    do_reset();
    for (int unsigned k = 0; k < 1872; k++) step();
    check("pre_midreset_out", 32'(out), 32'hFFFF);
    rst_n = 1'b0;
    step();
    check("midreset_out", 32'(out), 32'h0);
    check("midreset_ps", 32'(period_start), 32'h0);
    rst_n = 1'b1;
    first_ps = 0;
    for (int unsigned k = 1; k <= 4000; k++) begin
      step();
      if (period_start && first_ps == 0) first_ps = k;
    end
    check("midreset_next_ps", first_ps, 3315);

    // Enable change mid-period shows after exactly one clk
    en_out = 16'h00FF;
    en_pwm = 16'h0000;
    do_reset();
    for (int unsigned k = 0; k < 500; k++) step();
    check("en_before", 32'(out), 32'h00FF);
    en_out = 16'hFF00;
    #1;
    check("en_same_cycle", 32'(out), 32'h00FF);
    step();
    check("en_one_clk", 32'(out), 32'hFF00);

    // Duty change mid-period at counter 0x50: 0x40 -> 0xC0
    en_out = 16'h0001;
    en_pwm = 16'h0001;
    duty   = 8'h40;
    do_reset();
    for (int unsigned k = 0; k < 1045; k++) step();
    check("duty_old_low", 32'(out[0]), 32'h0);
    duty = 8'hC0;
    step();
    step();
`ifdef PWM_SHADOW_EN
    check("duty_change_held", 32'(out[0]), 32'h0);
`else
    check("duty_change_now", 32'(out[0]), 32'h1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
